fft_sq_mag_collector: RTL and testbench
=======================================

// Module: fft_sq_mag_collector
// PURPOSE
//  Consumes the unloaded output stream of the FFT core (dv_fft_core, xk_index, xk_re, xk_im).
//  Computes the squared magnitude |X[k]|^2 = re^2 + im^2 per bin and writes it to the bin memory.
//  Tracks the peak bin of each frame and pulses frame_done once the last bin has been written.
//  Sits downstream of the FFT core, on the read side of the unload handshake issued by fft_controller.
// PARAMETERS
//  DATA_W   16    signed width of xk_re / xk_im
//  N_LOG2   10    log2(FFT points); bin address width
//  OUT_W    32    width of sq_mag (2*DATA_W; holds max 2*2^(2*DATA_W-2) = 2^31)
// PORTS
//  clock          in   1        system clock, all logic rising-edge
//  reset          in   1        synchronous, active-high
//  dv_fft_core    in   1        FFT output sample valid
//  xk_index       in   N_LOG2   bin index of current output sample
//  xk_re          in   DATA_W   signed real part
//  xk_im          in   DATA_W   signed imaginary part
//  we_out         out  1        bin memory write enable
//  addr_out       out  N_LOG2   bin memory write address
//  sq_mag_out     out  OUT_W    unsigned squared magnitude
//  busy           out  1        high from first accepted bin until frame_done
//  frame_done     out  1        one-cycle pulse, frame fully written, peak outputs valid
//  peak_val       out  OUT_W    largest sq_mag of last completed frame
//  peak_idx       out  N_LOG2   bin index of peak_val
//  err_index      out  1        sticky error flag, cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> IDLE; pipeline valid bits, expected index and running peak cleared.
//  - Pipeline, 2 stages, fixed:
//    - S1 registers re*re and im*im (signed multiplies), plus index and valid.
//    - S2 registers the unsigned sum onto sq_mag_out/addr_out with we_out=1.
//    - Sample with dv at cycle t -> we_out at t+2. No back-pressure; a sample with dv is never dropped once accepted.
//  - FSM states: IDLE, RUN, FLUSH, DONE.
//    - IDLE: dv with xk_index==0 -> accept, exp_idx=1, RUN, busy=1. dv with xk_index!=0 -> ignored, err_index=1.
//    - RUN: every dv accepted; dv gaps of any length allowed. xk_index!=exp_idx -> err_index=1, sample still written
//      at received xk_index, exp_idx=xk_index+1 (resync). Accepted index == 2^N_LOG2-1 -> FLUSH.
//    - FLUSH: wait until S1 and S2 are empty (2 cycles), then DONE.
//    - DONE: one cycle; frame_done=1; peak_val/peak_idx updated; running peak cleared; busy=0; -> IDLE.
//    - dv in FLUSH or DONE: ignored, err_index=1 (overrun).
//  - Peak tracking on S2 output: strict > comparison, so ties keep the lower (earlier) index. First bin of a frame
//    always loads. peak_val/peak_idx change only in DONE; held otherwise.
//  - Arithmetic: -2^(DATA_W-1) squared = 2^(2*DATA_W-2); the sum of two such squares fits OUT_W unsigned. No saturation needed.
//  - exp_idx wraps modulo 2^N_LOG2.
//  - Reset mid-frame: pipeline flushed without writing; no frame_done; err_index cleared.
// TESTING
//  1. Reset, then 1024 consecutive dv, index 0..1023, re=k, im=0:
//     -> 1024 writes, addr=k, sq_mag=k^2, first we 2 cycles after first dv; frame_done 1 cycle after last write;
//        peak_val=1046529, peak_idx=1023; err_index=0.
//  2. Same frame with random 0-5 cycle dv gaps, re=im=-32768 at every bin:
//     -> all sq_mag=2^31 with no overflow; peak_idx=0 (tie rule).
//  3. First dv with xk_index=5 in IDLE -> no write, err_index=1 and stays 1; a following normal frame completes with frame_done.
//  4. Index skip: 0..99 then 101..1023 -> err_index=1 at the dv carrying 101; 1023 writes total; frame_done still pulses.
//  5. Reset asserted at bin 500 -> we_out=0 next cycle, busy=0, no frame_done; a fresh frame after reset completes correctly.
//  6. dv asserted during FLUSH -> ignored (no extra write), err_index=1; peak from the completed frame is correct.

Source files
------------

// File: rtl/fft_sq_mag_collector.sv
// fft_sq_mag_collector
// Takes the unloaded FFT output stream, forms |X[k]|^2 = re^2 + im^2 per bin
// through a fixed two-stage pipeline, writes it to the bin memory, and tracks
// the peak bin of each frame.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   dv_fft_core  FFT output sample valid
//   xk_index     bin index of the current sample
//   xk_re/xk_im  signed real / imaginary parts
//   we_out       bin memory write enable (2 cycles after the accepted sample)
//   addr_out     bin memory write address
//   sq_mag_out   unsigned squared magnitude
//   busy         high from first accepted bin until frame_done
//   frame_done   one-cycle pulse, frame written, peak outputs valid
//   peak_val     largest sq_mag of the last completed frame
//   peak_idx     bin index of peak_val
//   err_index    sticky index/overrun error, cleared only by reset
//
// state    | meaning
// ST_IDLE  | waiting for a sample carrying bin 0
// ST_RUN   | accepting bins, checking index continuity
// ST_FLUSH | last bin accepted, draining the pipeline
// ST_DONE  | frame_done pulse, peak published, running peak cleared

module fft_sq_mag_collector #(
   parameter int DATA_W = 16,
   parameter int N_LOG2 = 10,
   parameter int OUT_W  = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     dv_fft_core,
   input  logic [N_LOG2-1:0]        xk_index,
   input  logic signed [DATA_W-1:0] xk_re,
   input  logic signed [DATA_W-1:0] xk_im,
   output logic                     we_out,
   output logic [N_LOG2-1:0]        addr_out,
   output logic [OUT_W-1:0]         sq_mag_out,
   output logic                     busy,
   output logic                     frame_done,
   output logic [OUT_W-1:0]         peak_val,
   output logic [N_LOG2-1:0]        peak_idx,
   output logic                     err_index
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

   localparam logic [N_LOG2-1:0] LAST_IDX = '1;

   state_t state, state_nxt;
   logic   accept, err_set, peak_load;

   logic [N_LOG2-1:0] exp_idx;

   logic                    s1_vld;
   logic [N_LOG2-1:0]       s1_idx;
   logic [OUT_W-1:0]        s1_re_sq, s1_im_sq;

   logic                    run_vld;
   logic [OUT_W-1:0]        run_val;
   logic [N_LOG2-1:0]       run_idx;

   // Operands are sign-extended to OUT_W so each product is exact; the
   // square of the most negative input is 2^(2*DATA_W-2) and stays positive.
   logic signed [OUT_W-1:0] re_ext, im_ext, re_sq, im_sq;

   assign re_ext = {{(OUT_W-DATA_W){xk_re[DATA_W-1]}}, xk_re};
   assign im_ext = {{(OUT_W-DATA_W){xk_im[DATA_W-1]}}, xk_im};
   assign re_sq  = re_ext * re_ext;
   assign im_sq  = im_ext * im_ext;

   // Strict > keeps the earlier bin on ties; the first write of a frame always loads.
   logic               s2_beats;
   logic [OUT_W-1:0]   merged_val;
   logic [N_LOG2-1:0]  merged_idx;

   assign s2_beats   = we_out && (!run_vld || (sq_mag_out > run_val));
   assign merged_val = s2_beats ? sq_mag_out : run_val;
   assign merged_idx = s2_beats ? addr_out   : run_idx;

   assign busy       = (state == ST_RUN) || (state == ST_FLUSH);
   assign frame_done = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      err_set   = 1'b0;
      peak_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dv_fft_core) begin
               if (xk_index == '0) begin
                  accept    = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (dv_fft_core) begin
               accept = 1'b1;
               if (xk_index != exp_idx) err_set = 1'b1;
               if (xk_index == LAST_IDX) state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (dv_fft_core) err_set = 1'b1;
            // S1 empty now means the last bin is on the write port this
            // cycle; fold it into the published peak on the way to DONE.
            if (!s1_vld) begin
               state_nxt = ST_DONE;
               peak_load = 1'b1;
            end
         end
         ST_DONE: begin
            if (dv_fft_core) err_set = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         exp_idx   <= '0;
         err_index <= 1'b0;
      end else begin
         state     <= state_nxt;
         err_index <= err_index | err_set;
         if (accept) exp_idx <= xk_index + N_LOG2'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_vld     <= 1'b0;
         s1_idx     <= '0;
         s1_re_sq   <= '0;
         s1_im_sq   <= '0;
         we_out     <= 1'b0;
         addr_out   <= '0;
         sq_mag_out <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_idx   <= xk_index;
            s1_re_sq <= re_sq;
            s1_im_sq <= im_sq;
         end
         we_out <= s1_vld;
         if (s1_vld) begin
            addr_out   <= s1_idx;
            sq_mag_out <= s1_re_sq + s1_im_sq;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         run_vld  <= 1'b0;
         run_val  <= '0;
         run_idx  <= '0;
         peak_val <= '0;
         peak_idx <= '0;
      end else begin
         if (state == ST_DONE) begin
            run_vld <= 1'b0;
            run_val <= '0;
            run_idx <= '0;
         end else if (s2_beats) begin
            run_vld <= 1'b1;
            run_val <= sq_mag_out;
            run_idx <= addr_out;
         end
         if (peak_load) begin
            peak_val <= merged_val;
            peak_idx <= merged_idx;
         end
      end
   end

endmodule

// File: tb/tb_fft_sq_mag_collector.sv
module tb_fft_sq_mag_collector;

   localparam int DATA_W = 16;
   localparam int N_LOG2 = 10;
   localparam int OUT_W  = 32;
   localparam int NBINS  = 1 << N_LOG2;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic                     dv_fft_core = 1'b0;
   logic [N_LOG2-1:0]        xk_index = '0;
   logic signed [DATA_W-1:0] xk_re = '0;
   logic signed [DATA_W-1:0] xk_im = '0;
   logic                     we_out;
   logic [N_LOG2-1:0]        addr_out;
   logic [OUT_W-1:0]         sq_mag_out;
   logic                     busy;
   logic                     frame_done;
   logic [OUT_W-1:0]         peak_val;
   logic [N_LOG2-1:0]        peak_idx;
   logic                     err_index;

   fft_sq_mag_collector #(.DATA_W(DATA_W), .N_LOG2(N_LOG2), .OUT_W(OUT_W)) dut (
      .clock(clock), .reset(reset), .dv_fft_core(dv_fft_core), .xk_index(xk_index),
      .xk_re(xk_re), .xk_im(xk_im), .we_out(we_out), .addr_out(addr_out),
      .sq_mag_out(sq_mag_out), .busy(busy), .frame_done(frame_done),
      .peak_val(peak_val), .peak_idx(peak_idx), .err_index(err_index)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Works in terms of rising-edge numbers: a sample accepted at edge e is
   // written after edge e+1; the last bin at edge e gives frame_done after
   // edge e+2; samples at edges e+1..e+3 fall in the flush/done window.
   typedef struct {
      int          idx;
      logic [31:0] mag;
   } bin_t;

   bin_t frame_q[$];
   int   edge_n    = 0;
   bit   model_ok  = 0;
   bit   in_frame  = 0;
   int   last_edge = -100;
   int   exp_idx_m = 0;
   bit   p_we = 0;
   logic [N_LOG2-1:0] p_addr = '0, pend_idx = '0, m_addr = '0, m_pk_idx = '0;
   logic [31:0]       p_mag = '0, pend_val = '0, m_mag = '0, m_pk_val = '0;
   logic m_we = 0, m_busy = 0, m_done = 0, m_err = 0;

   always @(posedge clock) begin : model
      bit     acc;
      bit     post;
      longint r, i;
      edge_n++;
      if (reset) begin
         model_ok  = 1;
         in_frame  = 0;
         last_edge = -100;
         exp_idx_m = 0;
         p_we = 0; m_we = 0; m_busy = 0; m_done = 0; m_err = 0;
         m_pk_val = '0; m_pk_idx = '0;
         frame_q.delete();
      end else if (model_ok) begin
         m_we = p_we; m_addr = p_addr; m_mag = p_mag;
         p_we = 0;
         acc  = 0;
         post = (edge_n - last_edge >= 1) && (edge_n - last_edge <= 3);
         if (dv_fft_core) begin
            if (post) m_err = 1;
            else if (in_frame) begin
               acc = 1;
               if (int'(xk_index) != exp_idx_m) m_err = 1;
            end else if (int'(xk_index) == 0) begin
               acc = 1;
               in_frame = 1;
               frame_q.delete();
            end else m_err = 1;
         end
         if (acc) begin
            r = xk_re;
            i = xk_im;
            p_we   = 1;
            p_addr = xk_index;
            p_mag  = 32'(r * r + i * i);
            frame_q.push_back('{int'(xk_index), p_mag});
            exp_idx_m = (int'(xk_index) + 1) % NBINS;
            if (int'(xk_index) == NBINS - 1) begin
               in_frame  = 0;
               last_edge = edge_n;
               pend_val  = frame_q[0].mag;
               pend_idx  = N_LOG2'(frame_q[0].idx);
               foreach (frame_q[k])
                  if (frame_q[k].mag > pend_val) begin
                     pend_val = frame_q[k].mag;
                     pend_idx = N_LOG2'(frame_q[k].idx);
                  end
            end
         end
         m_busy = in_frame || (edge_n - last_edge <= 1);
         m_done = (edge_n == last_edge + 2);
         if (m_done) begin
            m_pk_val = pend_val;
            m_pk_idx = pend_idx;
         end
      end
   end

   always @(negedge clock) begin
      if (model_ok) begin
         chk("we_out", 64'(we_out), 64'(m_we));
         if (m_we) begin
            chk("addr_out", 64'(addr_out), 64'(m_addr));
            chk("sq_mag_out", 64'(sq_mag_out), 64'(m_mag));
         end
         chk("busy", 64'(busy), 64'(m_busy));
         chk("frame_done", 64'(frame_done), 64'(m_done));
         chk("err_index", 64'(err_index), 64'(m_err));
         chk("peak_val", 64'(peak_val), 64'(m_pk_val));
         chk("peak_idx", 64'(peak_idx), 64'(m_pk_idx));
         if (we_out === 1'b1) wr_cnt++;
         if (frame_done === 1'b1) done_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic dv, input int idx, input int re, input int im);
      dv_fft_core = dv;
      xk_index    = N_LOG2'(idx);
      xk_re       = DATA_W'(re);
      xk_im       = DATA_W'(im);
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) send(1'b0, 0, 0, 0);
   endtask

   initial begin
      int w0, d0;
      reset = 1'b1;
      idle(3);
      chk("rst_we", 64'(we_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err_index), 64'd0);
      chk("rst_peak_val", 64'(peak_val), 64'd0);
      reset = 1'b0;
      idle(2);

      // 1: ramp re=k, im=0
      wr_cnt = 0; done_cnt = 0;
      for (int k = 0; k < NBINS; k++) begin
         send(1'b1, k, k, 0);
         if (k == 500) chk("t1_busy_mid", 64'(busy), 64'd1);
      end
      idle(6);
      chk("t1_writes", 64'(wr_cnt), 64'd1024);
      chk("t1_done", 64'(done_cnt), 64'd1);
      chk("t1_peak_val", 64'(peak_val), 64'd1046529);
      chk("t1_peak_idx", 64'(peak_idx), 64'd1023);
      chk("t1_err", 64'(err_index), 64'd0);

      // 2: most-negative inputs with random gaps
      wr_cnt = 0;
      for (int k = 0; k < NBINS; k++) begin
         send(1'b1, k, -32768, -32768);
         idle($urandom_range(0, 5));
      end
      idle(6);
      chk("t2_writes", 64'(wr_cnt), 64'd1024);
      chk("t2_peak_val", 64'(peak_val), 64'h8000_0000);
      chk("t2_peak_idx", 64'(peak_idx), 64'd0);

      // 3: bad first index in IDLE, then a normal frame
      wr_cnt = 0; d0 = done_cnt;
      send(1'b1, 5, 100, 100);
      idle(4);
      chk("t3_no_write", 64'(wr_cnt), 64'd0);
      chk("t3_err", 64'(err_index), 64'd1);
      for (int k = 0; k < NBINS; k++) begin
         if (k == 700) send(1'b1, k, -300, 400);
         else send(1'b1, k, k % 64, 0);
      end
      idle(6);
      chk("t3_done", 64'(done_cnt - d0), 64'd1);
      chk("t3_err_sticky", 64'(err_index), 64'd1);
      chk("t3_peak_val", 64'(peak_val), 64'd250000);
      chk("t3_peak_idx", 64'(peak_idx), 64'd700);

      // 4: index skip 100
      reset = 1'b1; idle(2); reset = 1'b0; idle(2);
      wr_cnt = 0; d0 = done_cnt;
      for (int k = 0; k < NBINS; k++) begin
         if (k != 100) send(1'b1, k, 7, 7);
         if (k == 99) chk("t4_err_before", 64'(err_index), 64'd0);
         if (k == 101) chk("t4_err_at_101", 64'(err_index), 64'd1);
      end
      idle(6);
      chk("t4_writes", 64'(wr_cnt), 64'd1023);
      chk("t4_done", 64'(done_cnt - d0), 64'd1);
      chk("t4_peak_val", 64'(peak_val), 64'd98);
      chk("t4_peak_idx", 64'(peak_idx), 64'd0);

      // 5: reset mid-frame, then a fresh frame
      d0 = done_cnt;
      for (int k = 0; k < 500; k++) send(1'b1, k, k, 1);
      reset = 1'b1;
      send(1'b1, 500, 500, 1);
      chk("t5_we_after_rst", 64'(we_out), 64'd0);
      chk("t5_busy_after_rst", 64'(busy), 64'd0);
      reset = 1'b0;
      idle(6);
      chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t5_err_cleared", 64'(err_index), 64'd0);
      wr_cnt = 0;
      for (int k = 0; k < NBINS; k++) send(1'b1, k, k, -k);
      idle(6);
      chk("t5_writes", 64'(wr_cnt), 64'd1024);
      chk("t5_done", 64'(done_cnt - d0), 64'd1);
      chk("t5_peak_val", 64'(peak_val), 64'd2093058);
      chk("t5_peak_idx", 64'(peak_idx), 64'd1023);

      // 6: dv during FLUSH
      reset = 1'b1; idle(2); reset = 1'b0; idle(2);
      wr_cnt = 0; d0 = done_cnt;
      for (int k = 0; k < NBINS; k++) send(1'b1, k, (k == 10) ? 5 : 0, 0);
      send(1'b1, 0, 100, 0);
      idle(6);
      chk("t6_writes", 64'(wr_cnt), 64'd1024);
      chk("t6_done", 64'(done_cnt - d0), 64'd1);
      chk("t6_err", 64'(err_index), 64'd1);
      chk("t6_peak_val", 64'(peak_val), 64'd25);
      chk("t6_peak_idx", 64'(peak_idx), 64'd10);
      chk("t6_busy_idle", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
